// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel brighten stage: pixel width, pixel type,
// full-scale constant and the input-side frame FSM encoding.
package pixel_pkg;

  localparam int PIX_W     = 8;
  localparam int SAT_CNT_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PIX_MAX = {PIX_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } brighten_state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry skid buffer: an output register plus one skid slot.
// Upstream ready is registered (it only depends on whether the skid slot
// will be occupied), so there is no combinational path from downstream
// ready to upstream ready. Order is strictly preserved.
module pixel_skid_buffer
  import pixel_pkg::*;
#(
  parameter int DATA_W = PIX_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data
);

  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_push;
  logic              w_pop;
  logic              w_out_free;
  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  assign w_push     = i_in_valid & r_in_ready;
  assign w_pop      = r_out_valid & i_out_ready;
  assign w_out_free = ~r_out_valid | w_pop;

  // Next-state for both slots: the output register refills from the skid slot first, then from the input.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_nxt  = 1'b1;
        w_out_data_nxt   = r_skid_data;
        w_skid_valid_nxt = w_push;
        if (w_push) begin
          w_skid_data_nxt = i_in_data;
        end else begin
          w_skid_data_nxt = r_skid_data;
        end
      end else begin
        w_out_valid_nxt  = w_push;
        w_skid_valid_nxt = 1'b0;
        if (w_push) begin
          w_out_data_nxt = i_in_data;
        end else begin
          w_out_data_nxt = r_out_data;
        end
      end
    end else begin
      if (w_push) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_data_nxt  = i_in_data;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
      end
    end
  end

  // Slot registers and registered upstream ready; ready stays low while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= {DATA_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_data  <= {DATA_W{1'b0}};
    end else begin
      r_in_ready   <= ~w_skid_valid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: rtl/pixel_brighten.sv
// Pixel brighten stage: restores intensity of a darkened pixel stream with a
// per-frame saturating left shift (0..3). The shift is latched on the first
// accepted pixel of each frame. Results pass through a 2-entry skid buffer.
// Optional build macro PIXEL_BRIGHTEN_STATS_EN adds the per-frame
// saturated-pixel counter; without it io_sat_count is tied to zero.
module pixel_brighten #(
  parameter int PIX_W     = 8,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [PIX_W-1:0]     io_in_bits,
  input  logic                 io_in_last,
  input  logic [1:0]           io_shift,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [PIX_W-1:0]     io_out_bits,
  output logic                 io_out_last,
  output logic [SAT_CNT_W-1:0] io_sat_count,
  output logic                 io_frame_done
);

  import pixel_pkg::*;

  localparam logic [PIX_W+2:0] L_MAX_WIDE = {3'b000, {PIX_W{1'b1}}};

  brighten_state_e  r_state;
  brighten_state_e  w_state_nxt;
  logic [1:0]       r_frame_shift;
  logic [1:0]       w_shift;
  logic             w_in_ready;
  logic             w_accept;
  logic [PIX_W+2:0] w_wide;
  logic             w_sat;
  logic [PIX_W-1:0] w_pix;
  logic             w_out_valid;
  logic [PIX_W:0]   w_out_data;
  logic             r_frame_done;

  assign w_accept = io_in_valid & w_in_ready;

  // Frame FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state: a last pixel always returns to IDLE, any other accepted pixel opens a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !io_in_last) begin
          w_state_nxt = IN_FRAME;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      IN_FRAME: begin
        if (w_accept && io_in_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IN_FRAME;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame FSM output: the first pixel of a frame uses the live shift, later pixels the latched one.
  always_comb begin
    w_shift = io_shift;
    case (r_state)
      IDLE:     w_shift = io_shift;
      IN_FRAME: w_shift = r_frame_shift;
      default:  w_shift = io_shift;
    endcase
  end

  // Latch the frame shift on the first accepted pixel of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_shift <= 2'd0;
    end else if (w_accept && (r_state == IDLE)) begin
      r_frame_shift <= io_shift;
    end else begin
      r_frame_shift <= r_frame_shift;
    end
  end

  // Saturating shift: widen by 3 bits so no shifted-out bit is lost before the compare.
  assign w_wide = {3'b000, io_in_bits} << w_shift;
  assign w_sat  = (w_wide > L_MAX_WIDE);
  assign w_pix  = w_sat ? {PIX_W{1'b1}} : w_wide[PIX_W-1:0];

  pixel_skid_buffer #(
    .DATA_W (PIX_W + 1)
  ) u_skid (
    .clock       (clock),
    .reset       (reset),
    .i_in_valid  (io_in_valid),
    .o_in_ready  (w_in_ready),
    .i_in_data   ({io_in_last, w_pix}),
    .o_out_valid (w_out_valid),
    .i_out_ready (io_out_ready),
    .o_out_data  (w_out_data)
  );

`ifdef PIXEL_BRIGHTEN_STATS_EN
  logic [SAT_CNT_W-1:0] r_sat_run;
  logic [SAT_CNT_W-1:0] r_sat_count;
  logic [SAT_CNT_W-1:0] w_sat_sum;

  // Running count including the current pixel, sticking at full scale instead of wrapping.
  always_comb begin
    w_sat_sum = r_sat_run;
    if (w_sat && (r_sat_run != {SAT_CNT_W{1'b1}})) begin
      w_sat_sum = r_sat_run + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_sat_sum = r_sat_run;
    end
  end

  // Accumulate per accepted pixel; publish and clear on the last pixel so the next frame starts at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sat_run   <= {SAT_CNT_W{1'b0}};
      r_sat_count <= {SAT_CNT_W{1'b0}};
    end else if (w_accept) begin
      if (io_in_last) begin
        r_sat_count <= w_sat_sum;
        r_sat_run   <= {SAT_CNT_W{1'b0}};
      end else begin
        r_sat_count <= r_sat_count;
        r_sat_run   <= w_sat_sum;
      end
    end else begin
      r_sat_count <= r_sat_count;
      r_sat_run   <= r_sat_run;
    end
  end

  assign io_sat_count = r_sat_count;
`else
  assign io_sat_count = {SAT_CNT_W{1'b0}};
`endif

  // One-cycle frame-done pulse after the output handshake that carries the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_valid & io_out_ready & w_out_data[PIX_W];
    end
  end

  assign io_in_ready   = w_in_ready;
  assign io_out_valid  = w_out_valid;
  assign io_out_bits   = w_out_data[PIX_W-1:0];
  assign io_out_last   = w_out_data[PIX_W];
  assign io_frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_brighten.sv
// Self-checking bench for pixel_brighten: spec-level model (queue of expected
// pixels, frame shift, per-frame saturation count) checked every cycle, plus
// literal expectations for the directed frames.
module tb_pixel_brighten;

`ifdef PIXEL_BRIGHTEN_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_in_bits;
  logic        io_in_last;
  logic [1:0]  io_shift;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_out_bits;
  logic        io_out_last;
  logic [15:0] io_sat_count;
  logic        io_frame_done;

  always #5 clock = ~clock;

  pixel_brighten dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_in_last    (io_in_last),
    .io_shift      (io_shift),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_out_last   (io_out_last),
    .io_sat_count  (io_sat_count),
    .io_frame_done (io_frame_done)
  );

  typedef struct {
    logic [7:0] bits;
    logic       last;
    int         acc_cyc;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         done_cnt = 0;
  exp_t       exp_q[$];
  logic [7:0] cap_q[$];
  bit         m_in_frame = 1'b0;
  int         m_shift = 0;
  int         m_frame_sat = 0;
  int         exp_sat_count = 0;
  bit         exp_done = 1'b0;
  bit         lat_chk = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_bits;
  logic       prev_last;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Model + compare: everything sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    int   s;
    int   w;
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_in_frame    = 1'b0;
      m_frame_sat   = 0;
      exp_sat_count = 0;
      exp_done      = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      check("frame_done", {31'd0, io_frame_done}, {31'd0, exp_done});
      check("sat_count", {16'd0, io_sat_count}, exp_sat_count);
      if (prev_stall) begin
        check("stall_valid", {31'd0, io_out_valid}, 32'd1);
        check("stall_bits", {24'd0, io_out_bits}, {24'd0, prev_bits});
        check("stall_last", {31'd0, io_out_last}, {31'd0, prev_last});
      end
      if (io_frame_done) done_cnt++;
      exp_done = 1'b0;
      if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_bits", {24'd0, io_out_bits}, {24'd0, e.bits});
          check("out_last", {31'd0, io_out_last}, {31'd0, e.last});
          if (lat_chk) check("latency", cyc - e.acc_cyc, 32'd1);
        end
        cap_q.push_back(io_out_bits);
        if (io_out_last) exp_done = 1'b1;
      end
      prev_stall = io_out_valid && !io_out_ready;
      prev_bits  = io_out_bits;
      prev_last  = io_out_last;
      if (io_in_valid && io_in_ready) begin
        s = m_in_frame ? m_shift : int'(io_shift);
        w = int'(io_in_bits) * (1 << s);
        e.bits    = (w > 255) ? 8'hFF : w[7:0];
        e.last    = io_in_last;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        if (w > 255) m_frame_sat++;
        if (io_in_last) begin
          exp_sat_count = STATS_ON ? ((m_frame_sat > 65535) ? 65535 : m_frame_sat) : 0;
          m_frame_sat   = 0;
          m_in_frame    = 1'b0;
        end else begin
          m_in_frame = 1'b1;
          m_shift    = s;
        end
      end
    end
  end

  // Present one pixel and hold it until accepted (bounded); returns just after the accepting edge.
  task automatic send(input logic [7:0] p, input logic l);
    bit ok;
    ok = 1'b0;
    io_in_valid = 1'b1;
    io_in_bits  = p;
    io_in_last  = l;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      ok = io_in_ready;
    end
    check("send_accepted", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
  endtask

  // Wait (bounded) for the model queue and the DUT output to empty, then let stats settle.
  task automatic wait_drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || io_out_valid); k++) begin
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_cap(input string name, input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3, input int n);
    logic [7:0] ref_v[4];
    ref_v[0] = v0; ref_v[1] = v1; ref_v[2] = v2; ref_v[3] = v3;
    check({name, "_count"}, cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size(); i++) begin
      check({name, "_pix"}, {24'd0, cap_q[i]}, {24'd0, ref_v[i]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  d0;
    int  c0;
    bit  rdone;
    int  left;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_bits   = 8'h00;
    io_in_last   = 1'b0;
    io_shift     = 2'd0;
    io_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    check("rst_out_bits", {24'd0, io_out_bits}, 32'd0);
    check("rst_out_last", {31'd0, io_out_last}, 32'd0);
    check("rst_in_ready", {31'd0, io_in_ready}, 32'd0);
    check("rst_sat_count", {16'd0, io_sat_count}, 32'd0);
    check("rst_frame_done", {31'd0, io_frame_done}, 32'd0);
    #2 reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", {31'd0, io_in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // Frame A: shift 1, two saturating pixels
    io_shift = 2'd1;
    cap_q.delete();
    d0 = done_cnt;
    send(8'h10, 1'b0); send(8'h7F, 1'b0); send(8'h80, 1'b0); send(8'hFF, 1'b1);
    wait_drain();
    check_cap("A", 8'h20, 8'hFE, 8'hFF, 8'hFF, 4);
    check("A_sat_lit", {16'd0, io_sat_count}, STATS_ON ? 32'd2 : 32'd0);
    check("A_done_once", done_cnt - d0, 32'd1);

    // Frame B: shift 0 ramp, pass-through, 1-cycle latency, 1 pixel/cycle
    io_shift = 2'd0;
    cap_q.delete();
    lat_chk = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 256; i++) send(i[7:0], i == 255);
    check("B_throughput_cycles", cyc - c0, 32'd256);
    wait_drain();
    lat_chk = 1'b0;
    check("B_count", cap_q.size(), 32'd256);
    for (int i = 0; i < 256 && i < cap_q.size(); i++) check("B_ramp", {24'd0, cap_q[i]}, i);
    check("B_sat_lit", {16'd0, io_sat_count}, 32'd0);

    // Frame C: shift changes mid-frame are ignored; next frame picks up the new value
    io_shift = 2'd2;
    cap_q.delete();
    send(8'h01, 1'b0);
    io_shift = 2'd0;
    send(8'h02, 1'b0); send(8'h40, 1'b1); send(8'h40, 1'b1);
    wait_drain();
    check_cap("C", 8'h04, 8'h08, 8'hFF, 8'h40, 4);

    // Frame D: 1000 random pixels with random downstream stalls
    cap_q.delete();
    rdone = 1'b0;
    fork
      begin
        left = 0;
        for (int i = 0; i < 1000; i++) begin
          if (left == 0) begin
            left = $urandom_range(1, 20);
            io_shift = 2'($urandom_range(0, 3));
          end else if ($urandom_range(0, 3) == 0) begin
            io_shift = 2'($urandom_range(0, 3));
          end
          left--;
          send(8'($urandom_range(0, 255)), (left == 0) || (i == 999));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clock);
          #1;
          io_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    io_out_ready = 1'b1;
    wait_drain();
    check("D_count", cap_q.size(), 32'd1000);

    // Frame E: reset mid-frame with the skid slot occupied
    io_shift = 2'd0;
    io_out_ready = 1'b0;
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    @(negedge clock);
    check("E_skid_full_ready", {31'd0, io_in_ready}, 32'd0);
    check("E_out_valid_held", {31'd0, io_out_valid}, 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("E_rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    check("E_rst_out_bits", {24'd0, io_out_bits}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    check("E_sat_after_rst", {16'd0, io_sat_count}, 32'd0);
    check("E_ready_after_rst", {31'd0, io_in_ready}, 32'd1);
    @(posedge clock);
    #1;
    io_shift = 2'd2;
    cap_q.delete();
    send(8'h50, 1'b0); send(8'h10, 1'b1);
    wait_drain();
    check_cap("E", 8'hFF, 8'h40, 8'h00, 8'h00, 2);
    check("E_sat_lit", {16'd0, io_sat_count}, STATS_ON ? 32'd1 : 32'd0);

    // Frame F: shift 3 on full-scale single-pixel frame
    io_shift = 2'd3;
    cap_q.delete();
    d0 = done_cnt;
    send(8'hFF, 1'b1);
    wait_drain();
    check_cap("F", 8'hFF, 8'h00, 8'h00, 8'h00, 1);
    check("F_sat_lit", {16'd0, io_sat_count}, STATS_ON ? 32'd1 : 32'd0);
    check("F_done_once", done_cnt - d0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
